mem_arbiter: RTL and testbench

- Sequences the single backing line memory between three requesters: I-cache line fill, D-cache line fill and D-cache line write-back.
- Sits between icache/dcache and a single-port 128-bit line memory.
- Owns a one-entry posted write-back buffer, a grant FSM and a round-robin pointer between the two read requesters.
- Only one memory transaction is outstanding at any time.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_arbiter_if.sv | 57 +++++
 rtl/mem_arbiter_wb_post_buf.sv | 48 ++++
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_arbiter.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the line-memory arbiter: FSM states, default
// geometry and requester identifiers used by the round-robin pointer.
package mem_arb_pkg;

    localparam int ADDR_BITS_DEF = 10;
    localparam int LINE_BITS_DEF = 128;

    // Requester identifiers held in the round-robin pointer
    localparam logic REQ_IC = 1'b0;
    localparam logic REQ_DC = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD_I = 2'd1,
        ST_RD_D = 2'd2,
        ST_WR   = 2'd3
    } arb_state_e;

    // The read requester that follows the one just served
    function automatic logic rr_other(input logic who);
        return (who == REQ_IC) ? REQ_DC : REQ_IC;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundles the cache-side and memory-side buses of the line-memory arbiter.
// slave  : the arbiter's view.
// master : the environment's view (caches plus line memory).
interface mem_arbiter_if #(
    parameter int ADDR_BITS = 10,
    parameter int LINE_BITS = 128
);
    // I-cache fill
    logic                 Ic_mem_req;
    logic [ADDR_BITS-1:0] Ic_mem_addr;
    logic [LINE_BITS-1:0] F_mem_inst;
    logic                 F_mem_valid;
    // D-cache fill
    logic                 Dc_mem_req;
    logic [ADDR_BITS-1:0] Dc_mem_addr;
    logic [LINE_BITS-1:0] MEM_data_line;
    logic                 MEM_mem_valid;
    // D-cache write-back post
    logic                 Dc_wb_we;
    logic [ADDR_BITS-1:0] Dc_wb_addr;
    logic [LINE_BITS-1:0] Dc_wb_wline;
    logic                 Dc_wb_busy;
    // Line memory
    logic                 Arb_mem_req;
    logic                 Arb_mem_we;
    logic [ADDR_BITS-1:0] Arb_mem_addr;
    logic [LINE_BITS-1:0] Arb_mem_wline;
    logic [LINE_BITS-1:0] Arb_mem_rline;
    logic                 Arb_mem_valid;
    // Status
    logic                 Arb_err;

    modport slave (
        input  Ic_mem_req, Ic_mem_addr,
        output F_mem_inst, F_mem_valid,
        input  Dc_mem_req, Dc_mem_addr,
        output MEM_data_line, MEM_mem_valid,
        input  Dc_wb_we, Dc_wb_addr, Dc_wb_wline,
        output Dc_wb_busy,
        output Arb_mem_req, Arb_mem_we, Arb_mem_addr, Arb_mem_wline,
        input  Arb_mem_rline, Arb_mem_valid,
        output Arb_err
    );

    modport master (
        output Ic_mem_req, Ic_mem_addr,
        input  F_mem_inst, F_mem_valid,
        output Dc_mem_req, Dc_mem_addr,
        input  MEM_data_line, MEM_mem_valid,
        output Dc_wb_we, Dc_wb_addr, Dc_wb_wline,
        input  Dc_wb_busy,
        input  Arb_mem_req, Arb_mem_we, Arb_mem_addr, Arb_mem_wline,
        output Arb_mem_rline, Arb_mem_valid,
        input  Arb_err
    );

endinterface

// File: rtl/mem_arbiter_wb_post_buf.sv
// One-entry posted write-back buffer. A post is accepted only while empty;
// a post while full is dropped and flagged as an overflow for that cycle.
module wb_post_buf
    import mem_arb_pkg::*;
#(
    parameter int ADDR_BITS = ADDR_BITS_DEF,
    parameter int LINE_BITS = LINE_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 post_we,
    input  logic [ADDR_BITS-1:0] post_addr,
    input  logic [LINE_BITS-1:0] post_line,
    input  logic                 clr,
    output logic                 valid,
    output logic [ADDR_BITS-1:0] addr,
    output logic [LINE_BITS-1:0] line,
    output logic                 ovf
);

    logic                 valid_r;
    logic [ADDR_BITS-1:0] addr_r;
    logic [LINE_BITS-1:0] line_r;

    // Capture a post into an empty entry, otherwise release on write completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            addr_r  <= '0;
            line_r  <= '0;
        end else if (post_we && !valid_r) begin
            valid_r <= 1'b1;
            addr_r  <= post_addr;
            line_r  <= post_line;
        end else if (clr) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign valid = valid_r;
    assign addr  = addr_r;
    assign line  = line_r;
    // Contents stay untouched on overflow; only the flag reports it
    assign ovf   = post_we & valid_r;

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter for the single-port line memory shared by I-cache fill, D-cache
// fill and D-cache write-back. Write-back always wins in IDLE; the two
// fills alternate through a round-robin pointer only when both ask at once.
// Exactly one memory transaction is in flight; every completion returns to
// IDLE, leaving one idle cycle between transactions.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_BITS = ADDR_BITS_DEF,
    parameter int LINE_BITS = LINE_BITS_DEF
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    arb_state_e           state_r, state_s;
    logic                 rr_r, rr_s;
    logic                 mem_we_r, mem_we_s;
    logic [ADDR_BITS-1:0] mem_addr_r, mem_addr_s;
    logic [LINE_BITS-1:0] mem_wline_r, mem_wline_s;
    logic                 err_r, err_s;

    logic                 wb_pending_s;
    logic                 buf_clr_s;
    logic                 buf_valid_s;
    logic [ADDR_BITS-1:0] buf_addr_s;
    logic [LINE_BITS-1:0] buf_line_s;
    logic                 buf_ovf_s;

    wb_post_buf #(
        .ADDR_BITS (ADDR_BITS),
        .LINE_BITS (LINE_BITS)
    ) u_wb_buf (
        .clk       (clk),
        .rst_n     (rst),
        .post_we   (bus.Dc_wb_we),
        .post_addr (bus.Dc_wb_addr),
        .post_line (bus.Dc_wb_wline),
        .clr       (buf_clr_s),
        .valid     (buf_valid_s),
        .addr      (buf_addr_s),
        .line      (buf_line_s),
        .ovf       (buf_ovf_s)
    );

    // A post seen this very cycle counts as pending, so it beats a same-cycle fill
    assign wb_pending_s = buf_valid_s | bus.Dc_wb_we;

    // State, round-robin pointer, transaction registers and sticky error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            rr_r        <= REQ_IC;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wline_r <= '0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            rr_r        <= rr_s;
            mem_we_r    <= mem_we_s;
            mem_addr_r  <= mem_addr_s;
            mem_wline_r <= mem_wline_s;
            err_r       <= err_s;
        end
    end

    // Arbitration in IDLE, completion detection in the busy states
    always_comb begin
        state_s     = state_r;
        rr_s        = rr_r;
        mem_we_s    = mem_we_r;
        mem_addr_s  = mem_addr_r;
        mem_wline_s = mem_wline_r;
        buf_clr_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (wb_pending_s) begin
                    state_s  = ST_WR;
                    mem_we_s = 1'b1;
                    // An empty buffer captures on this same edge, so take the bus copy
                    if (buf_valid_s) begin
                        mem_addr_s  = buf_addr_s;
                        mem_wline_s = buf_line_s;
                    end else begin
                        mem_addr_s  = bus.Dc_wb_addr;
                        mem_wline_s = bus.Dc_wb_wline;
                    end
                end else if (bus.Ic_mem_req && bus.Dc_mem_req) begin
                    mem_we_s    = 1'b0;
                    mem_wline_s = '0;
                    rr_s        = rr_other(rr_r);
                    if (rr_r == REQ_IC) begin
                        state_s    = ST_RD_I;
                        mem_addr_s = bus.Ic_mem_addr;
                    end else begin
                        state_s    = ST_RD_D;
                        mem_addr_s = bus.Dc_mem_addr;
                    end
                end else if (bus.Ic_mem_req) begin
                    state_s     = ST_RD_I;
                    mem_we_s    = 1'b0;
                    mem_addr_s  = bus.Ic_mem_addr;
                    mem_wline_s = '0;
                end else if (bus.Dc_mem_req) begin
                    state_s     = ST_RD_D;
                    mem_we_s    = 1'b0;
                    mem_addr_s  = bus.Dc_mem_addr;
                    mem_wline_s = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RD_I, ST_RD_D: begin
                if (bus.Arb_mem_valid) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            ST_WR: begin
                if (bus.Arb_mem_valid) begin
                    state_s   = ST_IDLE;
                    buf_clr_s = 1'b1;
                end else begin
                    state_s = ST_WR;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Sticky error: dropped post, or a memory completion nobody asked for
    always_comb begin
        err_s = err_r;
        if (buf_ovf_s || ((state_r == ST_IDLE) && bus.Arb_mem_valid)) begin
            err_s = 1'b1;
        end else begin
            err_s = err_r;
        end
    end

    assign bus.Arb_mem_req   = (state_r != ST_IDLE);
    assign bus.Arb_mem_we    = mem_we_r;
    assign bus.Arb_mem_addr  = mem_addr_r;
    assign bus.Arb_mem_wline = mem_wline_r;
    assign bus.Dc_wb_busy    = buf_valid_s;
    assign bus.Arb_err       = err_r;

    // Completion pulses and read data pass straight through to the granted cache only
    assign bus.F_mem_valid   = (state_r == ST_RD_I) & bus.Arb_mem_valid;
    assign bus.MEM_mem_valid = (state_r == ST_RD_D) & bus.Arb_mem_valid;
    assign bus.F_mem_inst    = (state_r == ST_RD_I) ? bus.Arb_mem_rline : '0;
    assign bus.MEM_data_line = (state_r == ST_RD_D) ? bus.Arb_mem_rline : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a fixed-latency (3-cycle) line memory.
module tb_mem_arbiter;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    mem_arbiter_if #(.ADDR_BITS(10), .LINE_BITS(128)) bus ();

    mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- line memory model, latency 3 ----------------
    logic [127:0]  wmem [0:1023];
    logic [1023:0] wvld;
    logic          model_valid;
    logic [127:0]  model_rline;
    logic          stale_valid;
    int            mcnt;
    int            wr_count;
    logic [9:0]    last_wr_addr;
    logic [127:0]  last_wr_line;

    function automatic logic [127:0] model_line(input logic [9:0] a);
        logic [31:0] a32;
        a32 = {22'd0, a};
        return {32'hDEAD0000 + a32, 32'h12345678, 32'hCAFE0000 + a32, a32 * 32'd3};
    endfunction

    assign bus.Arb_mem_valid = model_valid | stale_valid;
    assign bus.Arb_mem_rline = model_rline;

    initial begin
        wr_count     = 0;
        last_wr_addr = 10'd0;
        last_wr_line = 128'd0;
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            model_valid <= 1'b0;
            model_rline <= 128'd0;
            mcnt        <= 0;
            wvld        <= '0;
        end else if (model_valid) begin
            model_valid <= 1'b0;
            mcnt        <= 0;
        end else if (bus.Arb_mem_req) begin
            if (mcnt == 2) begin
                model_valid <= 1'b1;
                mcnt        <= 0;
                model_rline <= wvld[bus.Arb_mem_addr] ? wmem[bus.Arb_mem_addr]
                                                      : model_line(bus.Arb_mem_addr);
                if (bus.Arb_mem_we) begin
                    wmem[bus.Arb_mem_addr] <= bus.Arb_mem_wline;
                    wvld[bus.Arb_mem_addr] <= 1'b1;
                    wr_count               <= wr_count + 1;
                    last_wr_addr           <= bus.Arb_mem_addr;
                    last_wr_line           <= bus.Arb_mem_wline;
                end
            end else begin
                mcnt <= mcnt + 1;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        step();
        n_tests++; if (bus.Arb_mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", bus.Arb_mem_req); end
        n_tests++; if (bus.Arb_mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", bus.Arb_mem_we); end
        n_tests++; if (bus.Arb_mem_addr !== 10'd0) begin n_fail++; $display("FAIL reset_addr: got %h want 000", bus.Arb_mem_addr); end
        n_tests++; if (bus.F_mem_valid !== 1'b0 || bus.MEM_mem_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valids: got %b%b want 00", bus.F_mem_valid, bus.MEM_mem_valid); end
        n_tests++; if (bus.Dc_wb_busy !== 1'b0 || bus.Arb_err !== 1'b0) begin n_fail++; $display("FAIL reset_busy_err: got %b%b want 00", bus.Dc_wb_busy, bus.Arb_err); end
        rst = 1'b1;
        step();
    endtask

    task automatic test_lone_i_fill();
        bus.Ic_mem_req  = 1'b1;
        bus.Ic_mem_addr = 10'h004;
        step();
        n_tests++; if (bus.Arb_mem_req !== 1'b1 || bus.Arb_mem_we !== 1'b0) begin n_fail++; $display("FAIL lone_req_we: got %b%b want 10", bus.Arb_mem_req, bus.Arb_mem_we); end
        n_tests++; if (bus.Arb_mem_addr !== 10'h004) begin n_fail++; $display("FAIL lone_addr: got %h want 004", bus.Arb_mem_addr); end
        for (int i = 0; i < 2; i++) begin
            step();
            n_tests++; if (bus.F_mem_valid !== 1'b0) begin n_fail++; $display("FAIL lone_early_valid: cycle %0d got %b want 0", i, bus.F_mem_valid); end
        end
        step();
        n_tests++; if (bus.F_mem_valid !== 1'b1) begin n_fail++; $display("FAIL lone_valid: got %b want 1", bus.F_mem_valid); end
        n_tests++; if (bus.F_mem_inst !== 128'hDEAD0004_12345678_CAFE0004_0000000C) begin n_fail++; $display("FAIL lone_data: got %h want DEAD0004123456780CAFE00040000000C", bus.F_mem_inst); end
        n_tests++; if (bus.MEM_mem_valid !== 1'b0 || bus.MEM_data_line !== 128'd0) begin n_fail++; $display("FAIL lone_other_side: got %b %h want 0 0", bus.MEM_mem_valid, bus.MEM_data_line); end
        bus.Ic_mem_req = 1'b0;
        step();
        n_tests++; if (bus.Arb_mem_req !== 1'b0 || bus.F_mem_valid !== 1'b0) begin n_fail++; $display("FAIL lone_after: got req %b valid %b want 0 0", bus.Arb_mem_req, bus.F_mem_valid); end
    endtask

    task automatic test_contention();
        do_reset();
        for (int round = 0; round < 2; round++) begin
            bus.Ic_mem_req  = 1'b1;
            bus.Ic_mem_addr = 10'h010;
            bus.Dc_mem_req  = 1'b1;
            bus.Dc_mem_addr = 10'h011;
            for (int g = 0; g < 2; g++) begin
                // round 0: I then D; round 1: D then I
                logic exp_i;
                exp_i = (round == 0) ? (g == 0) : (g == 1);
                if (g == 1) begin
                    step();
                    n_tests++; if (bus.Arb_mem_req !== 1'b0) begin n_fail++; $display("FAIL cont_turnaround: r%0d got %b want 0", round, bus.Arb_mem_req); end
                end
                step();
                n_tests++; if (bus.Arb_mem_req !== 1'b1 || bus.Arb_mem_addr !== (exp_i ? 10'h010 : 10'h011)) begin n_fail++; $display("FAIL cont_grant: r%0d g%0d got req %b addr %h want 1 %h", round, g, bus.Arb_mem_req, bus.Arb_mem_addr, exp_i ? 10'h010 : 10'h011); end
                step();
                step();
                step();
                if (exp_i) begin
                    n_tests++; if (bus.F_mem_valid !== 1'b1 || bus.MEM_mem_valid !== 1'b0 || bus.F_mem_inst !== 128'hDEAD0010_12345678_CAFE0010_00000030) begin n_fail++; $display("FAIL cont_i_done: r%0d got %b%b %h want 10 DEAD0010123456780CAFE001000000030", round, bus.F_mem_valid, bus.MEM_mem_valid, bus.F_mem_inst); end
                    bus.Ic_mem_req = 1'b0;
                end else begin
                    n_tests++; if (bus.MEM_mem_valid !== 1'b1 || bus.F_mem_valid !== 1'b0 || bus.MEM_data_line !== 128'hDEAD0011_12345678_CAFE0011_00000033) begin n_fail++; $display("FAIL cont_d_done: r%0d got %b%b %h want 10 DEAD0011123456780CAFE001100000033", round, bus.MEM_mem_valid, bus.F_mem_valid, bus.MEM_data_line); end
                    bus.Dc_mem_req = 1'b0;
                end
            end
            step();
        end
    endtask

    task automatic test_same_cycle_post_read();
        bus.Dc_wb_we    = 1'b1;
        bus.Dc_wb_addr  = 10'h020;
        bus.Dc_wb_wline = 128'h0123456789ABCDEF_FEDCBA9876543210;
        bus.Dc_mem_req  = 1'b1;
        bus.Dc_mem_addr = 10'h020;
        step();
        bus.Dc_wb_we = 1'b0;
        n_tests++; if (bus.Arb_mem_req !== 1'b1 || bus.Arb_mem_we !== 1'b1 || bus.Arb_mem_addr !== 10'h020) begin n_fail++; $display("FAIL post_wr_first: got req %b we %b addr %h want 1 1 020", bus.Arb_mem_req, bus.Arb_mem_we, bus.Arb_mem_addr); end
        n_tests++; if (bus.Arb_mem_wline !== 128'h0123456789ABCDEF_FEDCBA9876543210) begin n_fail++; $display("FAIL post_wline: got %h want 0123456789ABCDEFFEDCBA9876543210", bus.Arb_mem_wline); end
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (bus.Dc_wb_busy !== 1'b1 || bus.MEM_mem_valid !== 1'b0) begin n_fail++; $display("FAIL post_busy: cycle %0d got busy %b valid %b want 1 0", i, bus.Dc_wb_busy, bus.MEM_mem_valid); end
            step();
        end
        // write completes in this cycle; still no cache pulse
        n_tests++; if (bus.MEM_mem_valid !== 1'b0 || bus.F_mem_valid !== 1'b0 || bus.Dc_wb_busy !== 1'b1) begin n_fail++; $display("FAIL post_wr_done: got valids %b%b busy %b want 00 1", bus.MEM_mem_valid, bus.F_mem_valid, bus.Dc_wb_busy); end
        step();
        n_tests++; if (bus.Dc_wb_busy !== 1'b0 || bus.Arb_mem_req !== 1'b0) begin n_fail++; $display("FAIL post_release: got busy %b req %b want 0 0", bus.Dc_wb_busy, bus.Arb_mem_req); end
        step();
        n_tests++; if (bus.Arb_mem_req !== 1'b1 || bus.Arb_mem_we !== 1'b0 || bus.Arb_mem_addr !== 10'h020) begin n_fail++; $display("FAIL post_rd_issue: got req %b we %b addr %h want 1 0 020", bus.Arb_mem_req, bus.Arb_mem_we, bus.Arb_mem_addr); end
        step();
        step();
        step();
        n_tests++; if (bus.MEM_mem_valid !== 1'b1 || bus.MEM_data_line !== 128'h0123456789ABCDEF_FEDCBA9876543210) begin n_fail++; $display("FAIL post_rd_data: got %b %h want 1 0123456789ABCDEFFEDCBA9876543210", bus.MEM_mem_valid, bus.MEM_data_line); end
        bus.Dc_mem_req = 1'b0;
        step();
    endtask

    task automatic test_wb_overflow();
        int wr_before;
        wr_before = wr_count;
        n_tests++; if (bus.Arb_err !== 1'b0) begin n_fail++; $display("FAIL ovf_err_pre: got %b want 0", bus.Arb_err); end
        bus.Dc_wb_we    = 1'b1;
        bus.Dc_wb_addr  = 10'h030;
        bus.Dc_wb_wline = {4{32'h11111111}};
        step();
        bus.Dc_wb_addr  = 10'h031;
        bus.Dc_wb_wline = {4{32'h22222222}};
        step();
        bus.Dc_wb_we = 1'b0;
        n_tests++; if (bus.Arb_err !== 1'b1) begin n_fail++; $display("FAIL ovf_err: got %b want 1", bus.Arb_err); end
        n_tests++; if (bus.Arb_mem_addr !== 10'h030 || bus.Arb_mem_wline !== {4{32'h11111111}}) begin n_fail++; $display("FAIL ovf_hold: got %h %h want 030 11111111111111111111111111111111", bus.Arb_mem_addr, bus.Arb_mem_wline); end
        for (int i = 0; i < 6; i++) step();
        n_tests++; if (wr_count - wr_before !== 1) begin n_fail++; $display("FAIL ovf_wr_count: got %0d want 1", wr_count - wr_before); end
        n_tests++; if (last_wr_addr !== 10'h030 || last_wr_line !== {4{32'h11111111}}) begin n_fail++; $display("FAIL ovf_wr_line: got %h %h want 030 11111111111111111111111111111111", last_wr_addr, last_wr_line); end
        n_tests++; if (bus.Arb_mem_req !== 1'b0 || bus.Dc_wb_busy !== 1'b0 || bus.Arb_err !== 1'b1) begin n_fail++; $display("FAIL ovf_end: got req %b busy %b err %b want 0 0 1", bus.Arb_mem_req, bus.Dc_wb_busy, bus.Arb_err); end
    endtask

    task automatic test_reset_mid();
        bus.Dc_mem_req  = 1'b1;
        bus.Dc_mem_addr = 10'h040;
        step();
        n_tests++; if (bus.Arb_mem_req !== 1'b1 || bus.Arb_mem_addr !== 10'h040) begin n_fail++; $display("FAIL mid_issue: got %b %h want 1 040", bus.Arb_mem_req, bus.Arb_mem_addr); end
        step();
        rst = 1'b0;
        #1;
        n_tests++; if (bus.Arb_mem_req !== 1'b0) begin n_fail++; $display("FAIL mid_req_drop: got %b want 0", bus.Arb_mem_req); end
        n_tests++; if (bus.Arb_mem_we !== 1'b0 || bus.Arb_mem_addr !== 10'd0 || bus.Arb_mem_wline !== 128'd0) begin n_fail++; $display("FAIL mid_bus_zero: got %b %h %h want 0 0 0", bus.Arb_mem_we, bus.Arb_mem_addr, bus.Arb_mem_wline); end
        n_tests++; if (bus.F_mem_valid !== 1'b0 || bus.MEM_mem_valid !== 1'b0 || bus.MEM_data_line !== 128'd0 || bus.F_mem_inst !== 128'd0) begin n_fail++; $display("FAIL mid_cache_zero: got %b%b %h %h want 00 0 0", bus.F_mem_valid, bus.MEM_mem_valid, bus.MEM_data_line, bus.F_mem_inst); end
        n_tests++; if (bus.Dc_wb_busy !== 1'b0 || bus.Arb_err !== 1'b0) begin n_fail++; $display("FAIL mid_busy_err: got %b%b want 00", bus.Dc_wb_busy, bus.Arb_err); end
        bus.Dc_mem_req = 1'b0;
        step();
        rst = 1'b1;
        step();
        stale_valid = 1'b1;
        #1;
        n_tests++; if (bus.F_mem_valid !== 1'b0 || bus.MEM_mem_valid !== 1'b0 || bus.MEM_data_line !== 128'd0) begin n_fail++; $display("FAIL stale_valid: got %b%b %h want 00 0", bus.F_mem_valid, bus.MEM_mem_valid, bus.MEM_data_line); end
        step();
        stale_valid = 1'b0;
        n_tests++; if (bus.Arb_mem_req !== 1'b0 || bus.MEM_mem_valid !== 1'b0) begin n_fail++; $display("FAIL stale_after: got req %b valid %b want 0 0", bus.Arb_mem_req, bus.MEM_mem_valid); end
        step();
    endtask

    initial begin
        n_tests         = 0;
        n_fail          = 0;
        rst             = 1'b0;
        stale_valid     = 1'b0;
        bus.Ic_mem_req  = 1'b0;
        bus.Ic_mem_addr = 10'd0;
        bus.Dc_mem_req  = 1'b0;
        bus.Dc_mem_addr = 10'd0;
        bus.Dc_wb_we    = 1'b0;
        bus.Dc_wb_addr  = 10'd0;
        bus.Dc_wb_wline = 128'd0;

        test_reset();
        test_lone_i_fill();
        test_contention();
        test_same_cycle_post_read();
        test_wb_overflow();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
